// File: rtl/tlb_req_router_pkg.sv
// Shared types and default configuration for the L1-TLB to L2-TLB request router.
package tlb_req_router_pkg;

  localparam int DEF_NUM_CH          = 2;
  localparam int DEF_NUM_OUT         = 1;
  localparam int DEF_NUM_RES_IN      = 2;
  localparam int DEF_FIFO_DEPTH      = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_REQ_W           = 128;
  localparam int DEF_RES_W           = 128;
  localparam int DEF_CH_W            = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;

  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  // Flush epoch: toggles on every flush so late responses can be recognised.
  typedef logic epoch_t;
  typedef logic [DEF_CH_W-1:0] chan_t;

endpackage

// File: rtl/tlb_req_fifo.sv
// Single-clock request FIFO with occupancy count and synchronous clear.
module tlb_req_fifo #(
  parameter int  DEPTH = 4,
  parameter int  W     = 128,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/tlb_req_router.sv
// Round-robin arbiter from per-channel L1 TLB request FIFOs onto L2 TLB request
// ports, with per-channel outstanding limits and epoch-filtered response routing.
module tlb_req_router
  import tlb_req_router_pkg::*;
#(
  parameter int  NUM_CH          = DEF_NUM_CH,
  parameter int  NUM_OUT         = DEF_NUM_OUT,
  parameter int  NUM_RES_IN      = DEF_NUM_RES_IN,
  parameter int  FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int  MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int  REQ_W           = DEF_REQ_W,
  parameter int  RES_W           = DEF_RES_W,
  localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [NUM_CH-1:0]                 req_in_valid,
  input  logic [NUM_CH*REQ_W-1:0]           req_in_data,
  output logic [NUM_CH-1:0]                 req_in_ready,
  output logic [NUM_OUT-1:0]                req_out_valid,
  output logic [NUM_OUT*REQ_W-1:0]          req_out_data,
  output logic [NUM_OUT*CH_W-1:0]           req_out_chan,
  output logic [NUM_OUT-1:0]                req_out_epoch,
  input  logic [NUM_OUT-1:0]                req_out_ready,
  input  logic [NUM_RES_IN-1:0]             res_in_valid,
  input  logic [NUM_RES_IN*CH_W-1:0]        res_in_chan,
  input  logic [NUM_RES_IN-1:0]             res_in_epoch,
  input  logic [NUM_RES_IN*RES_W-1:0]       res_in_data,
  output logic [NUM_CH*NUM_RES_IN-1:0]      res_out_valid,
  output logic [NUM_CH*NUM_RES_IN*RES_W-1:0] res_out_data,
  output logic [15:0]                       dropped_cnt
);

  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int NSLOT = NUM_CH * NUM_RES_IN;

  logic [FCW-1:0]    fifo_cnt  [NUM_CH];
  logic [REQ_W-1:0]  fifo_dout [NUM_CH];
  logic [NUM_CH-1:0] push, pop, eligible, underflow;

  epoch_t            epoch_q;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [NUM_OUT-1:0] out_valid_q, out_valid_d, out_epoch_q, out_epoch_d;
  logic [REQ_W-1:0]  out_data_q [NUM_OUT];
  logic [REQ_W-1:0]  out_data_d [NUM_OUT];
  logic [CH_W-1:0]   out_chan_q [NUM_OUT];
  logic [CH_W-1:0]   out_chan_d [NUM_OUT];
  logic [OCW-1:0]    outst_q [NUM_CH];
  logic [OCW-1:0]    outst_d [NUM_CH];
  logic [NSLOT-1:0]  res_v_q, res_v_d;
  logic [RES_W-1:0]  res_data_q [NSLOT];
  logic [RES_W-1:0]  res_data_d [NSLOT];
  logic [15:0]       dropped_q, dropped_d;

  logic [CH_W-1:0]       res_chan [NUM_RES_IN];
  logic [NUM_RES_IN-1:0] res_match;

  int idx, last, slot, dec_n, nxt, drop_sum;
  logic found;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign req_in_ready[c] = (fifo_cnt[c] != FCW'(FIFO_DEPTH)) && !flush;
    assign push[c]         = req_in_valid[c] && req_in_ready[c];
    assign eligible[c]     = (fifo_cnt[c] != '0) && (outst_q[c] < OCW'(MAX_OUTSTANDING));

    tlb_req_fifo #(.DEPTH(FIFO_DEPTH), .W(REQ_W)) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .clear_i     (flush),
      .push_i      (push[c]),
      .push_data_i (req_in_data[c*REQ_W +: REQ_W]),
      .pop_i       (pop[c]),
      .pop_data_o  (fifo_dout[c]),
      .count_o     (fifo_cnt[c])
    );
  end

  for (genvar i = 0; i < NUM_RES_IN; i++) begin : g_res
    assign res_chan[i]  = res_in_chan[i*CH_W +: CH_W];
    assign res_match[i] = res_in_valid[i] && (res_in_epoch[i] == epoch_q) &&
                          (int'(res_chan[i]) < NUM_CH);
  end

  // Each free port, lowest first, takes the next eligible channel in
  // round-robin order; the pop mask doubles as the "already granted" mask.
  always_comb begin
    pop         = '0;
    out_valid_d = out_valid_q;
    out_epoch_d = out_epoch_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_d        = rr_q;
    last        = -1;
    idx         = 0;
    found       = 1'b0;
    for (int p = 0; p < NUM_OUT; p++) begin
      if (!out_valid_q[p] || req_out_ready[p]) begin
        out_valid_d[p] = 1'b0;
        found          = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
          idx = int'(rr_q) + k;
          if (idx >= NUM_CH) idx = idx - NUM_CH;
          if (!found && eligible[idx] && !pop[idx]) begin
            found          = 1'b1;
            pop[idx]       = 1'b1;
            out_valid_d[p] = 1'b1;
            out_data_d[p]  = fifo_dout[idx];
            out_chan_d[p]  = CH_W'(idx);
            out_epoch_d[p] = epoch_q;
            last           = idx;
          end
        end
      end
    end
    if (last >= 0) rr_d = (last + 1 >= NUM_CH) ? '0 : CH_W'(last + 1);
  end

  always_comb begin
    underflow = '0;
    dec_n     = 0;
    nxt       = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      dec_n = 0;
      for (int i = 0; i < NUM_RES_IN; i++) begin
        if (res_match[i] && (int'(res_chan[i]) == c)) dec_n = dec_n + 1;
      end
      nxt          = int'(outst_q[c]) + int'(pop[c]) - dec_n;
      underflow[c] = (nxt < 0);
      outst_d[c]   = OCW'(nxt);
    end
  end

  // Accepted responses are packed into the lowest free slots of their channel.
  always_comb begin
    res_v_d  = '0;
    slot     = 0;
    drop_sum = int'(dropped_q);
    for (int s = 0; s < NSLOT; s++) res_data_d[s] = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      slot = 0;
      for (int i = 0; i < NUM_RES_IN; i++) begin
        if (res_match[i] && (int'(res_chan[i]) == c)) begin
          res_v_d[c*NUM_RES_IN + slot]    = 1'b1;
          res_data_d[c*NUM_RES_IN + slot] = res_in_data[i*RES_W +: RES_W];
          slot = slot + 1;
        end
      end
    end
    for (int i = 0; i < NUM_RES_IN; i++) begin
      if (res_in_valid[i] && !res_match[i]) drop_sum = drop_sum + 1;
    end
    dropped_d = (drop_sum > int'(DROP_SAT)) ? DROP_SAT : 16'(drop_sum);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      epoch_q     <= '0;
      rr_q        <= '0;
      out_valid_q <= '0;
      out_epoch_q <= '0;
      res_v_q     <= '0;
      dropped_q   <= '0;
      for (int p = 0; p < NUM_OUT; p++) begin
        out_data_q[p] <= '0;
        out_chan_q[p] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) outst_q[c] <= '0;
      for (int s = 0; s < NSLOT; s++) res_data_q[s] <= '0;
    end else if (flush) begin
      epoch_q     <= ~epoch_q;
      out_valid_q <= '0;
      res_v_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) outst_q[c] <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_epoch_q <= out_epoch_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      outst_q     <= outst_d;
      res_v_q     <= res_v_d;
      res_data_q  <= res_data_d;
      dropped_q   <= dropped_d;
    end
  end

  a_no_underflow : assert property (@(posedge clock) disable iff (reset)
    flush || (underflow == '0));

  for (genvar p = 0; p < NUM_OUT; p++) begin : g_out
    assign req_out_data[p*REQ_W +: REQ_W] = out_data_q[p];
    assign req_out_chan[p*CH_W +: CH_W]   = out_chan_q[p];
  end
  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    assign res_out_data[s*RES_W +: RES_W] = res_data_q[s];
  end

  assign req_out_valid = out_valid_q;
  assign req_out_epoch = out_epoch_q;
  assign res_out_valid = res_v_q;
  assign dropped_cnt   = dropped_q;

endmodule
